sc_mask_split: RTL and testbench
================================

Name: sc_mask_split

Overview:
- Inverse of the datapath's bitwise OR combiner. Takes one NUMBER_DATAWIDTH-bit word and splits it back into its single-bit (one-hot) components, lowest set bit first.
- Emits one component per accepted valid/ack handshake.
- Sits after ALU logic results. Feeds per-bit consumers such as flag dispatch, register-select and interrupt-source servicing.

Parameters:
- NUMBER_DATAWIDTH, 8, width of input word and one-hot output mask.
- NUMBER_INDEXWIDTH, 3, width of bit index output; must equal clog2(NUMBER_DATAWIDTH).

Ports:
- SC_MASK_SPLIT_CLOCK_50  input  1  single system clock, rising edge.
- SC_MASK_SPLIT_RESET_InLow  input  1  asynchronous, active-low reset.
- SC_MASK_SPLIT_data_In  input  NUMBER_DATAWIDTH  word to split.
- SC_MASK_SPLIT_load_In  input  1  load request; sampled only when ready_Out=1.
- SC_MASK_SPLIT_ack_In  input  1  consumer accepts the current component.
- SC_MASK_SPLIT_clear_In  input  1  synchronous abort.
- SC_MASK_SPLIT_ready_Out  output  1  block idle, can accept a load.
- SC_MASK_SPLIT_valid_Out  output  1  mask_Out/index_Out hold a valid component.
- SC_MASK_SPLIT_mask_Out  output  NUMBER_DATAWIDTH  one-hot component.
- SC_MASK_SPLIT_index_Out  output  NUMBER_INDEXWIDTH  bit position of mask_Out.
- SC_MASK_SPLIT_count_Out  output  NUMBER_INDEXWIDTH+1  components emitted for the current word.
- SC_MASK_SPLIT_done_Out  output  1  one-cycle pulse after the last component (or after an empty word).

Behaviour:
- Reset:
  - Asynchronous on RESET_InLow=0. Takes effect immediately, including mid-split.
  - Resulting state IDLE, work register 0.
  - ready_Out=1; valid_Out=0, mask_Out=0, index_Out=0, count_Out=0, done_Out=0.
- All outputs are registered. No combinational path from any input to any output.
- FSM states: IDLE, EMIT, DONE.
- IDLE:
  - ready_Out=1, valid_Out=0.
  - On load_In=1:
    - Capture data_In into the work register.
    - Set count_Out to 0.
    - If data_In≠0: go to EMIT. Load mask_Out with the lowest set bit (data_In & -data_In) and index_Out with its position.
    - If data_In=0: go to DONE.
  - Latency is 1 cycle: valid_Out rises on the edge after load.
- EMIT:
  - ready_Out=0, valid_Out=1. mask_Out/index_Out stay stable until ack_In=1.
  - On ack_In=1:
    - Clear that bit from the work register. count_Out increments by 1.
    - If remaining work≠0: mask_Out/index_Out update to the next lowest set bit on the same edge, so one component per cycle is possible with ack held high.
    - If remaining work=0: go to DONE. Set valid_Out=0, mask_Out=0, index_Out=0.
- DONE:
  - done_Out=1 for exactly one cycle; count_Out holds the final popcount.
  - Next cycle: go to IDLE. count_Out holds its value until the next load.
- Ignored inputs:
  - load_In outside IDLE has no effect; data_In is not resampled.
  - ack_In outside EMIT has no effect.
- clear_In:
  - From any state, go to IDLE on the next edge.
  - Sets valid_Out=0, mask_Out=0, index_Out=0, count_Out=0, work=0. No done pulse.
  - Priority: clear_In over ack_In over load_In.
- Boundaries:
  - All-ones word: NUMBER_DATAWIDTH components, final count_Out=NUMBER_DATAWIDTH. This is why count_Out is one bit wider.
  - MSB-only word: single component, index_Out=NUMBER_DATAWIDTH-1.
  - Empty word: DONE reached with count_Out=0 and no valid cycle.
- Invariant: mask_Out is exactly one-hot whenever valid_Out=1, and mask_Out = 1<<index_Out.

Decomposition:
- Shared package contents:
  - State encoding localparams STATE_IDLE=2'b00, STATE_EMIT=2'b01, STATE_DONE=2'b10.
  - DATAWIDTH/INDEXWIDTH defaults.
- One sub-module is natural: sc_lowbit_encoder.
  - Purely combinational.
  - Input: word. Outputs: one-hot lowest set bit, its index, and an any-bit-set flag.
  - Instantiated once, on the next-work value.
- The FSM, work register, counter and output registers live in sc_mask_split.

Test Plan:
- Reset mid-EMIT after loading 8'hA5 and one ack -> outputs immediately read ready=1, valid=0, mask=0, index=0, count=0.
- Load 8'b1010_0100, ack held high -> valid for 3 consecutive cycles with masks 8'h04,8'h20,8'h80 and indices 2,5,7. Then done pulse for 1 cycle with count=3, then ready=1.
- Load 8'h00 -> valid never asserted; done pulses on the cycle after load with count=0.
- Load 8'hFF, ack every other cycle -> 8 components, index 0..7. mask_Out stable while ack=0. Final count=8 (4'b1000).
- Load 8'h81, assert load_In with data 8'h10 during EMIT -> sequence remains 8'h01 then 8'h80; 8'h10 is never emitted.
- Load 8'h0F, one ack, then clear_In together with ack_In -> next cycle IDLE, valid=0, count=0, no done pulse. A subsequent load of 8'h40 emits index 6.

Source files
------------

// File: rtl/sc_mask_split_pkg.sv
// sc_mask_split_pkg
//   Shared definitions for the mask splitter: default widths and the
//   FSM state encoding used by sc_mask_split.
package sc_mask_split_pkg;

  localparam int DATAWIDTH  = 8;
  localparam int INDEXWIDTH = 3;

  localparam logic [1:0] STATE_IDLE = 2'b00;
  localparam logic [1:0] STATE_EMIT = 2'b01;
  localparam logic [1:0] STATE_DONE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = STATE_IDLE,
    ST_EMIT = STATE_EMIT,
    ST_DONE = STATE_DONE
  } state_e;

endpackage

// File: rtl/sc_lowbit_encoder.sv
// sc_lowbit_encoder
//   Purely combinational lowest-set-bit extractor.
//   Ports:
//     word      - input word
//     low_mask  - one-hot mask of the lowest set bit (0 when word is 0)
//     low_index - position of that bit (0 when word is 0)
//     any_set   - 1 when word has at least one bit set
module sc_lowbit_encoder #(
  parameter int NUMBER_DATAWIDTH  = 8,
  parameter int NUMBER_INDEXWIDTH = 3
) (
  input  logic [NUMBER_DATAWIDTH-1:0]  word,
  output logic [NUMBER_DATAWIDTH-1:0]  low_mask,
  output logic [NUMBER_INDEXWIDTH-1:0] low_index,
  output logic                         any_set
);

  localparam logic [NUMBER_DATAWIDTH-1:0] DATA_ONE = {{(NUMBER_DATAWIDTH-1){1'b0}}, 1'b1};

  logic [NUMBER_DATAWIDTH-1:0]  low_mask_s;
  logic [NUMBER_INDEXWIDTH-1:0] low_index_s;

  // Isolate the lowest set bit (two's complement trick) and encode its position.
  always_comb begin
    low_mask_s  = word & (~word + DATA_ONE);
    low_index_s = {NUMBER_INDEXWIDTH{1'b0}};
    for (int i = 0; i < NUMBER_DATAWIDTH; i++) begin
      // low_mask_s is one-hot, so OR-ing the selected positions yields the index.
      low_index_s = low_index_s |
                    (low_mask_s[i] ? NUMBER_INDEXWIDTH'(i) : {NUMBER_INDEXWIDTH{1'b0}});
    end
  end

  assign low_mask  = low_mask_s;
  assign low_index = low_index_s;
  assign any_set   = |word;

endmodule

// File: rtl/sc_mask_split.sv
// sc_mask_split
//   Splits a word into its one-hot components, lowest set bit first, one
//   component per valid/ack handshake. All outputs are registered.
//   Ports:
//     SC_MASK_SPLIT_CLOCK_50     - clock, rising edge
//     SC_MASK_SPLIT_RESET_InLow  - asynchronous active-low reset
//     SC_MASK_SPLIT_data_In      - word to split
//     SC_MASK_SPLIT_load_In      - load request (honoured only while idle)
//     SC_MASK_SPLIT_ack_In       - consumer accepts current component
//     SC_MASK_SPLIT_clear_In     - synchronous abort back to idle
//     SC_MASK_SPLIT_ready_Out    - idle, can accept a load
//     SC_MASK_SPLIT_valid_Out    - mask/index hold a valid component
//     SC_MASK_SPLIT_mask_Out     - one-hot component
//     SC_MASK_SPLIT_index_Out    - bit position of mask_Out
//     SC_MASK_SPLIT_count_Out    - components emitted for the current word
//     SC_MASK_SPLIT_done_Out     - one-cycle pulse after the last component
module sc_mask_split
  import sc_mask_split_pkg::*;
#(
  parameter int NUMBER_DATAWIDTH  = DATAWIDTH,
  parameter int NUMBER_INDEXWIDTH = INDEXWIDTH
) (
  input  logic                         SC_MASK_SPLIT_CLOCK_50,
  input  logic                         SC_MASK_SPLIT_RESET_InLow,
  input  logic [NUMBER_DATAWIDTH-1:0]  SC_MASK_SPLIT_data_In,
  input  logic                         SC_MASK_SPLIT_load_In,
  input  logic                         SC_MASK_SPLIT_ack_In,
  input  logic                         SC_MASK_SPLIT_clear_In,
  output logic                         SC_MASK_SPLIT_ready_Out,
  output logic                         SC_MASK_SPLIT_valid_Out,
  output logic [NUMBER_DATAWIDTH-1:0]  SC_MASK_SPLIT_mask_Out,
  output logic [NUMBER_INDEXWIDTH-1:0] SC_MASK_SPLIT_index_Out,
  output logic [NUMBER_INDEXWIDTH:0]   SC_MASK_SPLIT_count_Out,
  output logic                         SC_MASK_SPLIT_done_Out
);

  localparam logic [NUMBER_INDEXWIDTH:0] COUNT_ONE = {{NUMBER_INDEXWIDTH{1'b0}}, 1'b1};

  state_e                       state_r,  state_next_s;
  logic [NUMBER_DATAWIDTH-1:0]  work_r,   work_next_s;
  logic [NUMBER_INDEXWIDTH:0]   count_r,  count_next_s;
  logic [NUMBER_DATAWIDTH-1:0]  mask_r,   mask_next_s;
  logic [NUMBER_INDEXWIDTH-1:0] index_r,  index_next_s;
  logic                         valid_r,  valid_next_s;
  logic                         ready_r,  ready_next_s;
  logic                         done_r,   done_next_s;

  logic [NUMBER_DATAWIDTH-1:0]  enc_mask_s;
  logic [NUMBER_INDEXWIDTH-1:0] enc_index_s;
  logic                         enc_any_s;

  // The encoder looks at the next work value, so the component presented
  // after an ack is already the following bit (one component per cycle).
  sc_lowbit_encoder #(
    .NUMBER_DATAWIDTH (NUMBER_DATAWIDTH),
    .NUMBER_INDEXWIDTH(NUMBER_INDEXWIDTH)
  ) u_lowbit (
    .word     (work_next_s),
    .low_mask (enc_mask_s),
    .low_index(enc_index_s),
    .any_set  (enc_any_s)
  );

  // Next-state, work-register and counter logic; clear beats ack beats load.
  always_comb begin
    state_next_s = state_r;
    work_next_s  = work_r;
    count_next_s = count_r;
    if (SC_MASK_SPLIT_clear_In) begin
      state_next_s = ST_IDLE;
      work_next_s  = {NUMBER_DATAWIDTH{1'b0}};
      count_next_s = {(NUMBER_INDEXWIDTH+1){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (SC_MASK_SPLIT_load_In) begin
            work_next_s  = SC_MASK_SPLIT_data_In;
            count_next_s = {(NUMBER_INDEXWIDTH+1){1'b0}};
            if (SC_MASK_SPLIT_data_In != {NUMBER_DATAWIDTH{1'b0}}) begin
              state_next_s = ST_EMIT;
            end else begin
              state_next_s = ST_DONE;
            end
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_EMIT: begin
          if (SC_MASK_SPLIT_ack_In) begin
            // mask_r is the bit just accepted; drop it from the work word.
            work_next_s  = work_r & ~mask_r;
            count_next_s = count_r + COUNT_ONE;
            if ((work_r & ~mask_r) != {NUMBER_DATAWIDTH{1'b0}}) begin
              state_next_s = ST_EMIT;
            end else begin
              state_next_s = ST_DONE;
            end
          end else begin
            state_next_s = ST_EMIT;
          end
        end
        ST_DONE: begin
          state_next_s = ST_IDLE;
        end
        default: begin
          state_next_s = ST_IDLE;
          work_next_s  = {NUMBER_DATAWIDTH{1'b0}};
          count_next_s = {(NUMBER_INDEXWIDTH+1){1'b0}};
        end
      endcase
    end
  end

  // Output values for the next cycle, all derived from the next state.
  always_comb begin
    valid_next_s = (state_next_s == ST_EMIT);
    ready_next_s = (state_next_s == ST_IDLE);
    done_next_s  = (state_next_s == ST_DONE) && !SC_MASK_SPLIT_clear_In;
    if (valid_next_s && enc_any_s) begin
      mask_next_s  = enc_mask_s;
      index_next_s = enc_index_s;
    end else begin
      mask_next_s  = {NUMBER_DATAWIDTH{1'b0}};
      index_next_s = {NUMBER_INDEXWIDTH{1'b0}};
    end
  end

  // State, work and output registers.
  always_ff @(posedge SC_MASK_SPLIT_CLOCK_50 or negedge SC_MASK_SPLIT_RESET_InLow) begin
    if (!SC_MASK_SPLIT_RESET_InLow) begin
      state_r <= ST_IDLE;
      work_r  <= {NUMBER_DATAWIDTH{1'b0}};
      count_r <= {(NUMBER_INDEXWIDTH+1){1'b0}};
      mask_r  <= {NUMBER_DATAWIDTH{1'b0}};
      index_r <= {NUMBER_INDEXWIDTH{1'b0}};
      valid_r <= 1'b0;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      work_r  <= work_next_s;
      count_r <= count_next_s;
      mask_r  <= mask_next_s;
      index_r <= index_next_s;
      valid_r <= valid_next_s;
      ready_r <= ready_next_s;
      done_r  <= done_next_s;
    end
  end

  assign SC_MASK_SPLIT_ready_Out = ready_r;
  assign SC_MASK_SPLIT_valid_Out = valid_r;
  assign SC_MASK_SPLIT_mask_Out  = mask_r;
  assign SC_MASK_SPLIT_index_Out = index_r;
  assign SC_MASK_SPLIT_count_Out = count_r;
  assign SC_MASK_SPLIT_done_Out  = done_r;

endmodule

// File: tb/tb_sc_mask_split.sv
// tb_sc_mask_split
//   Directed self-checking bench for sc_mask_split. Inputs change and
//   outputs are sampled 1 time unit after each rising clock edge.
module tb_sc_mask_split;

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic       load;
  logic       ack;
  logic       clear;
  logic       ready;
  logic       valid;
  logic [7:0] mask;
  logic [2:0] index;
  logic [3:0] count;
  logic       done;

  int total;
  int bad;

  // Observed output vector: {ready, valid, mask, index, count, done}
  logic [17:0] obs;
  assign obs = {ready, valid, mask, index, count, done};

  sc_mask_split dut (
    .SC_MASK_SPLIT_CLOCK_50   (clk),
    .SC_MASK_SPLIT_RESET_InLow(rst_n),
    .SC_MASK_SPLIT_data_In    (data),
    .SC_MASK_SPLIT_load_In    (load),
    .SC_MASK_SPLIT_ack_In     (ack),
    .SC_MASK_SPLIT_clear_In   (clear),
    .SC_MASK_SPLIT_ready_Out  (ready),
    .SC_MASK_SPLIT_valid_Out  (valid),
    .SC_MASK_SPLIT_mask_Out   (mask),
    .SC_MASK_SPLIT_index_Out  (index),
    .SC_MASK_SPLIT_count_Out  (count),
    .SC_MASK_SPLIT_done_Out   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] ev(input logic r, input logic v, input logic [7:0] m,
                                     input logic [2:0] i, input logic [3:0] c, input logic d);
    return {r, v, m, i, c, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data = 8'h00; load = 1'b0; ack = 1'b0; clear = 1'b0;
    #12;
    total++; if (obs !== ev(1'b1, 1'b0, 8'h00, 3'd0, 4'd0, 1'b0)) begin bad++; $display("FAIL reset_init got=%h exp=%h", obs, ev(1'b1, 1'b0, 8'h00, 3'd0, 4'd0, 1'b0)); end
    rst_n = 1'b1;
    step();
    // Load A5, accept one component, then reset mid-split.
    data = 8'hA5; load = 1'b1;
    step();
    total++; if (obs !== ev(1'b0, 1'b1, 8'h01, 3'd0, 4'd0, 1'b0)) begin bad++; $display("FAIL a5_first got=%h exp=%h", obs, ev(1'b0, 1'b1, 8'h01, 3'd0, 4'd0, 1'b0)); end
    load = 1'b0; ack = 1'b1;
    step();
    total++; if (obs !== ev(1'b0, 1'b1, 8'h04, 3'd2, 4'd1, 1'b0)) begin bad++; $display("FAIL a5_second got=%h exp=%h", obs, ev(1'b0, 1'b1, 8'h04, 3'd2, 4'd1, 1'b0)); end
    ack = 1'b0; rst_n = 1'b0;
    #1;
    total++; if (obs !== ev(1'b1, 1'b0, 8'h00, 3'd0, 4'd0, 1'b0)) begin bad++; $display("FAIL reset_mid_emit got=%h exp=%h", obs, ev(1'b1, 1'b0, 8'h00, 3'd0, 4'd0, 1'b0)); end
    #2;
    rst_n = 1'b1;
    step();
    total++; if (obs !== ev(1'b1, 1'b0, 8'h00, 3'd0, 4'd0, 1'b0)) begin bad++; $display("FAIL after_reset_idle got=%h exp=%h", obs, ev(1'b1, 1'b0, 8'h00, 3'd0, 4'd0, 1'b0)); end
  endtask

  task automatic test_ack_held();
    data = 8'b1010_0100; load = 1'b1; ack = 1'b1;
    step();
    load = 1'b0;
    total++; if (obs !== ev(1'b0, 1'b1, 8'h04, 3'd2, 4'd0, 1'b0)) begin bad++; $display("FAIL held_c0 got=%h exp=%h", obs, ev(1'b0, 1'b1, 8'h04, 3'd2, 4'd0, 1'b0)); end
    step();
    total++; if (obs !== ev(1'b0, 1'b1, 8'h20, 3'd5, 4'd1, 1'b0)) begin bad++; $display("FAIL held_c1 got=%h exp=%h", obs, ev(1'b0, 1'b1, 8'h20, 3'd5, 4'd1, 1'b0)); end
    step();
    total++; if (obs !== ev(1'b0, 1'b1, 8'h80, 3'd7, 4'd2, 1'b0)) begin bad++; $display("FAIL held_c2 got=%h exp=%h", obs, ev(1'b0, 1'b1, 8'h80, 3'd7, 4'd2, 1'b0)); end
    step();
    total++; if (obs !== ev(1'b0, 1'b0, 8'h00, 3'd0, 4'd3, 1'b1)) begin bad++; $display("FAIL held_done got=%h exp=%h", obs, ev(1'b0, 1'b0, 8'h00, 3'd0, 4'd3, 1'b1)); end
    ack = 1'b0;
    step();
    total++; if (obs !== ev(1'b1, 1'b0, 8'h00, 3'd0, 4'd3, 1'b0)) begin bad++; $display("FAIL held_idle got=%h exp=%h", obs, ev(1'b1, 1'b0, 8'h00, 3'd0, 4'd3, 1'b0)); end
  endtask

  task automatic test_empty();
    data = 8'h00; load = 1'b1;
    step();
    load = 1'b0;
    total++; if (obs !== ev(1'b0, 1'b0, 8'h00, 3'd0, 4'd0, 1'b1)) begin bad++; $display("FAIL empty_done got=%h exp=%h", obs, ev(1'b0, 1'b0, 8'h00, 3'd0, 4'd0, 1'b1)); end
    step();
    total++; if (obs !== ev(1'b1, 1'b0, 8'h00, 3'd0, 4'd0, 1'b0)) begin bad++; $display("FAIL empty_idle got=%h exp=%h", obs, ev(1'b1, 1'b0, 8'h00, 3'd0, 4'd0, 1'b0)); end
  endtask

  task automatic test_all_ones();
    logic [7:0] m;
    data = 8'hFF; load = 1'b1; ack = 1'b0;
    step();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m = 8'h01 << i;
      total++; if (obs !== ev(1'b0, 1'b1, m, 3'(i), 4'(i), 1'b0)) begin bad++; $display("FAIL ff_comp%0d got=%h exp=%h", i, obs, ev(1'b0, 1'b1, m, 3'(i), 4'(i), 1'b0)); end
      step();
      total++; if (obs !== ev(1'b0, 1'b1, m, 3'(i), 4'(i), 1'b0)) begin bad++; $display("FAIL ff_stable%0d got=%h exp=%h", i, obs, ev(1'b0, 1'b1, m, 3'(i), 4'(i), 1'b0)); end
      ack = 1'b1;
      step();
      ack = 1'b0;
    end
    total++; if (obs !== ev(1'b0, 1'b0, 8'h00, 3'd0, 4'b1000, 1'b1)) begin bad++; $display("FAIL ff_done got=%h exp=%h", obs, ev(1'b0, 1'b0, 8'h00, 3'd0, 4'b1000, 1'b1)); end
    step();
    total++; if (obs !== ev(1'b1, 1'b0, 8'h00, 3'd0, 4'b1000, 1'b0)) begin bad++; $display("FAIL ff_idle got=%h exp=%h", obs, ev(1'b1, 1'b0, 8'h00, 3'd0, 4'b1000, 1'b0)); end
  endtask

  task automatic test_load_ignored();
    data = 8'h81; load = 1'b1;
    step();
    total++; if (obs !== ev(1'b0, 1'b1, 8'h01, 3'd0, 4'd0, 1'b0)) begin bad++; $display("FAIL ign_c0 got=%h exp=%h", obs, ev(1'b0, 1'b1, 8'h01, 3'd0, 4'd0, 1'b0)); end
    data = 8'h10; ack = 1'b1;
    step();
    total++; if (obs !== ev(1'b0, 1'b1, 8'h80, 3'd7, 4'd1, 1'b0)) begin bad++; $display("FAIL ign_c1 got=%h exp=%h", obs, ev(1'b0, 1'b1, 8'h80, 3'd7, 4'd1, 1'b0)); end
    step();
    total++; if (obs !== ev(1'b0, 1'b0, 8'h00, 3'd0, 4'd2, 1'b1)) begin bad++; $display("FAIL ign_done got=%h exp=%h", obs, ev(1'b0, 1'b0, 8'h00, 3'd0, 4'd2, 1'b1)); end
    load = 1'b0; ack = 1'b0;
    step();
    total++; if (obs !== ev(1'b1, 1'b0, 8'h00, 3'd0, 4'd2, 1'b0)) begin bad++; $display("FAIL ign_idle got=%h exp=%h", obs, ev(1'b1, 1'b0, 8'h00, 3'd0, 4'd2, 1'b0)); end
  endtask

  task automatic test_clear();
    data = 8'h0F; load = 1'b1;
    step();
    load = 1'b0; ack = 1'b1;
    step();
    total++; if (obs !== ev(1'b0, 1'b1, 8'h02, 3'd1, 4'd1, 1'b0)) begin bad++; $display("FAIL clr_pre got=%h exp=%h", obs, ev(1'b0, 1'b1, 8'h02, 3'd1, 4'd1, 1'b0)); end
    clear = 1'b1;
    step();
    total++; if (obs !== ev(1'b1, 1'b0, 8'h00, 3'd0, 4'd0, 1'b0)) begin bad++; $display("FAIL clr_idle got=%h exp=%h", obs, ev(1'b1, 1'b0, 8'h00, 3'd0, 4'd0, 1'b0)); end
    clear = 1'b0; ack = 1'b0;
    step();
    total++; if (obs !== ev(1'b1, 1'b0, 8'h00, 3'd0, 4'd0, 1'b0)) begin bad++; $display("FAIL clr_nodone got=%h exp=%h", obs, ev(1'b1, 1'b0, 8'h00, 3'd0, 4'd0, 1'b0)); end
    data = 8'h40; load = 1'b1;
    step();
    load = 1'b0;
    total++; if (obs !== ev(1'b0, 1'b1, 8'h40, 3'd6, 4'd0, 1'b0)) begin bad++; $display("FAIL clr_reload got=%h exp=%h", obs, ev(1'b0, 1'b1, 8'h40, 3'd6, 4'd0, 1'b0)); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    total++; if (obs !== ev(1'b0, 1'b0, 8'h00, 3'd0, 4'd1, 1'b1)) begin bad++; $display("FAIL clr_msb_done got=%h exp=%h", obs, ev(1'b0, 1'b0, 8'h00, 3'd0, 4'd1, 1'b1)); end
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_ack_held();
    test_empty();
    test_all_ones();
    test_load_ignored();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
